// File: rtl/axis_img_border_strip.sv
// axis_img_border_strip: drops the one-pixel border of a bordered AXI4-Stream frame and reframes the interior
module axis_img_border_strip #(
  parameter int          IMG_RES_X         = 336,
  parameter int          IMG_RES_Y         = 256,
  parameter logic [15:0] DATA_PIX_CLR_MASK = 16'h0000
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [1:0]  s_axis_tuser,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        err_sync,
  input  logic        err_clr,
  output logic        frame_done
);
  typedef enum logic [1:0] {ST_BORDER_ROW, ST_ROW_FIRST, ST_DATA, ST_ROW_LAST} state_t;
  localparam logic [15:0] XD = 16'(IMG_RES_X);
  localparam logic [15:0] XL = 16'(IMG_RES_X + 1);
  localparam logic [15:0] YL = 16'(IMG_RES_Y + 1);
  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        err_q, err_d, fd_q, fd_d;
  logic        in_data, acc, at_end, row_end, last_row, load;
  logic        unused_in;
  assign unused_in = s_axis_tlast ^ s_axis_tuser[0];
  // Border beats are always taken and dropped; a row end comes from the count or the tuser[1] marker
  always_comb begin
    in_data       = state_q == ST_DATA;
    s_axis_tready = in_data ? (~tvalid_q | m_axis_tready) : 1'b1;
    acc           = s_axis_tvalid & s_axis_tready;
    at_end        = x_q == XL;
    row_end       = acc & (at_end | s_axis_tuser[1]);
    last_row      = y_q == YL;
    load          = acc & in_data & ~s_axis_tuser[1];
    x_d           = row_end ? '0 : acc ? x_q + 16'd1 : x_q;
    y_d           = row_end ? (last_row ? '0 : y_q + 16'd1) : y_q;
    state_d       = row_end ? ((last_row | (y_q + 16'd1 == YL)) ? ST_BORDER_ROW : ST_ROW_FIRST) :
                    ~acc ? state_q :
                    state_q == ST_ROW_FIRST ? ST_DATA :
                    (in_data & (x_q == XD)) ? ST_ROW_LAST : state_q;
    fd_d          = row_end & last_row;
    tdata_d       = load ? (s_axis_tdata & ~DATA_PIX_CLR_MASK) : tdata_q;
    tuser_d       = load ? (x_q == 16'd1) & (y_q == 16'd1) : tuser_q;
    tlast_d       = load ? x_q == XD : tlast_q;
    tvalid_d      = load | (tvalid_q & ~m_axis_tready);
    err_d         = (acc & (s_axis_tuser[1] ^ at_end)) | (err_q & ~err_clr);
  end
  // Counters, state and the single output register stage
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= ST_BORDER_ROW;
      x_q      <= '0;
      y_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      err_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      err_q    <= err_d;
      fd_q     <= fd_d;
    end
  end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign err_sync      = err_q;
  assign frame_done    = fd_q;
endmodule

// File: tb/tb_axis_img_border_strip.sv
// tb_axis_img_border_strip: randomized frames checked against a frame-level reference model
module tb_axis_img_border_strip;
  localparam int          X    = 4;
  localparam int          Y    = 3;
  localparam logic [15:0] MASK = 16'h8000;
  typedef struct packed {logic [15:0] d; logic u; logic l;} out_t;
  typedef struct packed {logic [15:0] d; logic m; logic bord;} in_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] s_tdata = '0, m_tdata;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [1:0]  s_tuser = '0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic        err_sync, err_clr = 1'b0, frame_done;
  in_t         in_q[$];
  out_t        exp_q[$];
  out_t        e;
  int          fl_q[$];
  int          total = 0, bad = 0;
  int          fd_cnt = 0, acc_cnt = 0, out_cnt = 0, cyc = 0, last_acc_cyc = 0;
  int          rdy_mode = 1;
  logic        gaps = 1'b0;
  always #5 clk = ~clk;
  axis_img_border_strip #(.IMG_RES_X(X), .IMG_RES_Y(Y), .DATA_PIX_CLR_MASK(MASK)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .err_sync(err_sync), .err_clr(err_clr), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Builds one bordered frame; row tr is cut short by a marker at x=tx, row nm lacks its marker
  task automatic send_frame(input int tr, input int tx, input int nm);
    int n = 0;
    in_t b;
    for (int y = 0; y <= Y + 1; y++) begin
      for (int x = 0; x <= X + 1; x++) begin
        logic trunc, bord;
        logic [15:0] d;
        trunc = (y == tr) && (x == tx);
        bord  = (y == 0) || (y == Y + 1) || (x == 0) || (x == X + 1);
        d     = (x == 1 && y == 1) ? 16'h8123 : 16'($urandom);
        in_q.push_back({d, trunc || (x == X + 1 && y != nm), bord});
        n++;
        if (!bord && !trunc) exp_q.push_back({d & ~MASK, x == 1 && y == 1, x == X});
        if (trunc) break;
      end
    end
    fl_q.push_back(n);
    while (in_q.size() > 0) begin
      int w = 0;
      b = in_q.pop_front();
      if (gaps && $urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata  = b.d;
      s_tuser  = {b.m, 1'b0};
      s_tvalid = 1'b1;
      forever begin
        @(negedge clk);
        if (b.bord) check("border_ready", s_tready, 1);
        if (s_tready) break;
        if (++w > 1000) begin
          $display("FAIL stall: got no s_tready expected accept within 1000 cycles");
          bad++;
          $fatal(1, "stall");
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("drain_left", exp_q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk); #1;
    m_tready = rdy_mode == 2 ? 1'($urandom_range(1)) : rdy_mode == 1;
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (frame_done) begin
        fd_cnt++;
        check("fd_latency", cyc - last_acc_cyc, 1);
        check("fd_accepts", acc_cnt, fl_q.size() > 0 ? fl_q.pop_front() : -1);
        acc_cnt = 0;
      end
      if (s_tvalid && s_tready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.d);
          check("out_tuser", m_tuser, e.u);
          check("out_tlast", m_tlast, e.l);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected end of test");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_err", err_sync, 0);
    check("rst_fd", frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(-1, -1, -1);
    drain();
    check("f1_outs", out_cnt, 12);
    check("f1_fd", fd_cnt, 1);
    check("f1_err", err_sync, 0);
    rdy_mode = 2;
    gaps = 1'b1;
    send_frame(-1, -1, -1);
    drain();
    check("f2_outs", out_cnt, 24);
    check("f2_fd", fd_cnt, 2);
    send_frame(2, 3, -1);
    drain();
    check("trunc_err", err_sync, 1);
    check("trunc_outs", out_cnt, 34);
    send_frame(-1, -1, -1);
    drain();
    check("after_trunc_outs", out_cnt, 46);
    check("err_sticky", err_sync, 1);
    check("f4_fd", fd_cnt, 4);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("err_cleared", err_sync, 0);
    send_frame(-1, -1, 1);
    drain();
    check("nomark_err", err_sync, 1);
    check("nomark_outs", out_cnt, 58);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    rdy_mode = 0;
    gaps = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_tdata  = 16'($urandom);
      s_tuser  = {i == 5, 1'b0};
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst_tvalid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_tvalid", m_tvalid, 0);
    s_tvalid = 1'b0;
    s_tuser  = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    acc_cnt  = 0;
    rdy_mode = 1;
    fd_cnt   = 0;
    out_cnt  = 0;
    check("post_rst_err", err_sync, 0);
    send_frame(-1, -1, -1);
    drain();
    check("post_rst_outs", out_cnt, 12);
    check("post_rst_fd", fd_cnt, 1);
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    drain();
    check("b2b_outs", out_cnt, 36);
    check("b2b_fd", fd_cnt, 3);
    check("b2b_err", err_sync, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_img_border_strip.md
Name: axis_img_border_strip

Overview:
- Inverse of the border generator in the BPR chain: takes a bordered AXI4-Stream frame of (IMG_RES_X+2) x (IMG_RES_Y+2) pixels and drops the one-pixel border, emitting the IMG_RES_X x IMG_RES_Y interior.
- Sits after the 3x3 kernel stages and restores standard framing: tuser on the first pixel, tlast on each row's last pixel.
- Uses the generator's row-end border marker (tuser[1]) to check alignment and resynchronise the counters.

Parameters:
- IMG_RES_X, 336, interior pixels per row.
- IMG_RES_Y, 256, interior rows per frame.
- DATA_PIX_CLR_MASK, 16'h0000, bits cleared on every output pixel (m_tdata = s_tdata & ~mask).

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  16  bordered pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  ignored
- s_axis_tuser  in  2  [1] row-end border pixel marker; [0] ignored
- m_axis_tdata  out  16  interior pixel, masked
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last interior pixel of a row
- m_axis_tuser  out  1  first interior pixel of a frame
- err_sync  out  1  sticky alignment error
- err_clr  in  1  synchronous clear of err_sync
- frame_done  out  1  one-cycle pulse after the last bordered pixel is accepted

Behaviour:
- Reset (async assert, sync release): x_cnt=0, y_cnt=0, state=ST_BORDER_ROW; all outputs 0. Reset mid-frame drops any held output beat; the next accepted beat is treated as frame pixel (0,0).
- A beat is accepted when s_tvalid & s_tready. Counters advance only on accepted beats.
- Border beat: y_cnt==0, y_cnt==IMG_RES_Y+1, x_cnt==0 or x_cnt==IMG_RES_X+1.
- Output register: one stage holding tdata/tlast/tuser/tvalid.
  - s_tready = 1 for border beats (these are discarded).
  - s_tready = ~m_tvalid | m_tready for interior beats.
  - Full throughput; s_tready has a combinational path from m_tready (accepted).
- Interior beat: loads the output register next cycle with masked data.
  - tuser = (x_cnt==1 & y_cnt==1).
  - tlast = (x_cnt==IMG_RES_X).
- m_tvalid clears on m_tready when no new interior beat is loaded in the same cycle. A simultaneous drain and load keeps m_tvalid=1.
- States:
  - ST_BORDER_ROW (y=0 or Y+1): discard all beats.
  - ST_ROW_FIRST (x=0): discard one beat, then go to ST_DATA.
  - ST_DATA (x=1..X): forward beats; after x=X go to ST_ROW_LAST.
  - ST_ROW_LAST (x=X+1): discard one beat, then row end.
- Row end is the accepted beat with x_cnt==IMG_RES_X+1.
  - x_cnt←0 and y_cnt←y_cnt+1.
  - Next state is ST_BORDER_ROW if the new y is Y+1, else ST_ROW_FIRST.
  - At y==Y+1 the row end instead sets y_cnt←0, pulses frame_done for 1 cycle, and enters ST_BORDER_ROW.
- Resync via tuser[1]:
  - tuser[1]=1 on an accepted beat with x_cnt≠X+1: set err_sync and force a row end on that beat. The beat is discarded even if in ST_DATA; any m_tlast for a partial row is lost.
  - tuser[1]=0 at x_cnt==X+1: set err_sync; the row end still occurs.
- err_sync holds until reset or err_clr. If err_clr and a new error coincide, err_sync stays set.
- Width rules: counters are 16 bits; IMG_RES_X+1 and IMG_RES_Y+1 must be < 65536.
- Latency: 1 cycle from interior-beat accept to m_tvalid.

Test Plan:
- IMG_RES_X=4, IMG_RES_Y=3, 30 bordered beats (6x5), tuser[1] on each x=5, m_tready=1.
  - 12 output beats with data equal to the interior ramp.
  - m_tuser only on beat 1; m_tlast on beats 4, 8 and 12.
  - frame_done pulses once, 1 cycle after the 30th accept.
  - err_sync=0.
- Same frame with m_tready toggled 1-0-0-1 randomly.
  - Output order and content unchanged; no beat lost or duplicated.
  - s_tready stays 1 on every border beat regardless of m_tready.
- DATA_PIX_CLR_MASK=16'h8000, interior input 16'h8123 -> output 16'h0123.
- tuser[1] asserted early at x=3 on row y=2.
  - err_sync=1.
  - Next beat counted as x=0 of y=3.
  - The following frame is correct and err_sync stays 1 until an err_clr pulse clears it.
- axis_aresetn pulled low mid-row while m_tvalid=1.
  - m_tvalid drops immediately (asynchronously).
  - After release, a full fresh frame produces the correct 12 beats.
- Two back-to-back frames with no gaps: 24 outputs, two frame_done pulses 30 accepts apart, m_tuser on beats 1 and 13.
